// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: record type codes, FSM state
// encodings, header field positions and a word-to-byte address helper.
package boot_loader_pkg;

  typedef enum logic [1:0] {
    BOOT_TYPE_INSTR = 2'b00,
    BOOT_TYPE_DATA  = 2'b01,
    BOOT_TYPE_START = 2'b10,
    BOOT_TYPE_RSVD  = 2'b11
  } boot_type_e;

  typedef enum logic [2:0] {
    BOOT_HDR   = 3'd0,
    BOOT_LOAD  = 3'd1,
    BOOT_RUN   = 3'd2,
    BOOT_ERROR = 3'd3,
    BOOT_CHK   = 3'd4
  } boot_state_e;

  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 30;
  localparam int HDR_RSVD_MSB = 29;
  localparam int HDR_RSVD_LSB = 16;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_CNT_LSB  = 0;

  // Payload word index to BRAM byte address (word k lives at k*4).
  function automatic logic [17:0] word_to_byte_addr(input logic [15:0] k);
    return {k, 2'b00};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Valid/ready word stream from the host word assembler into the loader.
interface boot_loader_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] s_dat;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_dat, output s_valid, input s_ready);
  modport slave  (input s_dat, input s_valid, output s_ready);
endinterface

// File: rtl/boot_loader_hdr_decode.sv
// Combinational header decoder: splits a header word into type and count and
// flags whether the record is well formed for the configured BRAM depths.
module boot_loader_hdr_decode
  import boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int I_DEPTH    = 256,
  parameter int D_DEPTH    = 256
) (
  input  logic [DATA_WIDTH-1:0] i_hdr,
  output boot_type_e            o_type,
  output logic [15:0]           o_cnt,
  output logic                  o_zero,
  output logic                  o_valid
);

  logic w_rsvd_ok;
  logic w_cnt_ok;

  // Field extraction and legality check of the header word.
  always_comb begin
    o_type    = boot_type_e'(i_hdr[HDR_TYPE_MSB:HDR_TYPE_LSB]);
    o_cnt     = i_hdr[HDR_CNT_MSB:HDR_CNT_LSB];
    o_zero    = (o_cnt == 16'd0);
    w_rsvd_ok = (i_hdr[HDR_RSVD_MSB:HDR_RSVD_LSB] == 14'd0);
    case (o_type)
      BOOT_TYPE_INSTR: w_cnt_ok = ({1'b0, o_cnt} <= 17'(I_DEPTH));
      BOOT_TYPE_DATA:  w_cnt_ok = ({1'b0, o_cnt} <= 17'(D_DEPTH));
      BOOT_TYPE_START: w_cnt_ok = 1'b1;
      default:         w_cnt_ok = 1'b0;
    endcase
    o_valid = w_rsvd_ok & w_cnt_ok;
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: parses framed records from a word stream, writes instruction
// and data payloads into their BRAMs, then releases the core on START.
// Optional macro BOOT_LOADER_CHECKSUM_EN adds a trailing per-record checksum
// word (32-bit wrapping sum of the payload) checked in a CHK state.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int I_DEPTH    = 256,
  parameter int D_DEPTH    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  boot_loader_if.slave          s_if,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  err
);

  boot_state_e           r_state, w_next;
  boot_type_e            r_type, w_hdr_type;
  logic [15:0]           r_cnt, r_k, w_hdr_cnt;
  logic                  w_hdr_zero, w_hdr_valid, w_acc, w_last, w_ready_next;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  r_s_ready, r_pc_stall, r_init_done, r_rd_en, r_err;
  logic                  r_i_w_enb, r_d_w_enb;
  logic [ADDR_WIDTH-1:0] r_i_w_addr, r_d_w_addr;
  logic [DATA_WIDTH-1:0] r_i_w_dat, r_d_w_dat;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
`endif

  boot_loader_hdr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .I_DEPTH(I_DEPTH), .D_DEPTH(D_DEPTH)
  ) u_hdr_decode (
    .i_hdr  (s_if.s_dat),
    .o_type (w_hdr_type),
    .o_cnt  (w_hdr_cnt),
    .o_zero (w_hdr_zero),
    .o_valid(w_hdr_valid)
  );

  assign w_acc     = s_if.s_valid & r_s_ready;
  assign w_last    = (r_k == (r_cnt - 16'd1));
  assign w_wr_addr = ADDR_WIDTH'(word_to_byte_addr(r_k));

  // Next-state decode of the record-parsing FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT_HDR: begin
        if (!w_acc)                              w_next = BOOT_HDR;
        else if (!w_hdr_valid)                   w_next = BOOT_ERROR;
        else if (w_hdr_type == BOOT_TYPE_START)  w_next = BOOT_RUN;
        else if (w_hdr_zero)                     w_next = BOOT_HDR;
        else                                     w_next = BOOT_LOAD;
      end
      BOOT_LOAD: begin
        if (w_acc && w_last) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          w_next = BOOT_CHK;
`else
          w_next = BOOT_HDR;
`endif
        end else begin
          w_next = BOOT_LOAD;
        end
      end
      BOOT_RUN:   w_next = reload ? BOOT_HDR : BOOT_RUN;
      BOOT_ERROR: w_next = reload ? BOOT_HDR : BOOT_ERROR;
`ifdef BOOT_LOADER_CHECKSUM_EN
      BOOT_CHK: begin
        if (!w_acc)                     w_next = BOOT_CHK;
        else if (s_if.s_dat == r_sum)   w_next = BOOT_HDR;
        else                            w_next = BOOT_ERROR;
      end
`endif
      default:    w_next = BOOT_ERROR;
    endcase
    w_ready_next = (w_next == BOOT_HDR) || (w_next == BOOT_LOAD) || (w_next == BOOT_CHK);
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= BOOT_HDR;
      r_s_ready   <= 1'b0;
      r_pc_stall  <= 1'b1;
      r_init_done <= 1'b0;
      r_rd_en     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_s_ready   <= w_ready_next;
      r_pc_stall  <= (w_next != BOOT_RUN);
      r_init_done <= (w_next == BOOT_RUN);
      r_rd_en     <= (w_next == BOOT_RUN);
      r_err       <= (w_next == BOOT_ERROR);
    end
  end

  // Record bookkeeping: latch type/count on a header, advance the word index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_type <= BOOT_TYPE_INSTR;
      r_cnt  <= 16'd0;
      r_k    <= 16'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_sum  <= '0;
`endif
    end else if (r_state == BOOT_HDR && w_acc) begin
      r_type <= w_hdr_type;
      r_cnt  <= w_hdr_cnt;
      r_k    <= 16'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_sum  <= '0;
`endif
    end else if (r_state == BOOT_LOAD && w_acc) begin
      r_k    <= r_k + 16'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_sum  <= r_sum + s_if.s_dat;
`endif
    end else begin
      r_k    <= r_k;
    end
  end

  // BRAM write ports: one-cycle enable pulse per accepted payload word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_w_enb  <= 1'b0;
      r_i_w_addr <= '0;
      r_i_w_dat  <= '0;
      r_d_w_enb  <= 1'b0;
      r_d_w_addr <= '0;
      r_d_w_dat  <= '0;
    end else begin
      r_i_w_enb <= 1'b0;
      r_d_w_enb <= 1'b0;
      if (r_state == BOOT_LOAD && w_acc) begin
        if (r_type == BOOT_TYPE_INSTR) begin
          r_i_w_enb  <= 1'b1;
          r_i_w_addr <= w_wr_addr;
          r_i_w_dat  <= s_if.s_dat;
        end else begin
          r_d_w_enb  <= 1'b1;
          r_d_w_addr <= w_wr_addr;
          r_d_w_dat  <= s_if.s_dat;
        end
      end
    end
  end

  assign s_if.s_ready     = r_s_ready;
  assign i_w_addr         = r_i_w_addr;
  assign i_w_dat          = r_i_w_dat;
  assign i_w_enb          = r_i_w_enb;
  assign d_w_addr         = r_d_w_addr;
  assign d_w_dat          = r_d_w_dat;
  assign d_w_enb          = r_d_w_enb;
  assign d_bram_init_done = r_init_done;
  assign pc_stall         = r_pc_stall;
  assign i_r_enb          = r_rd_en;
  assign rd_enbl          = r_rd_en;
  assign err              = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a header table drives whole records
// while a write monitor pops expected BRAM writes from a scoreboard queue.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reload = 1'b0;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb, d_bram_init_done, pc_stall, i_r_enb, rd_enbl, err;

  boot_loader_if #(.DATA_WIDTH(32)) s_if ();

  boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .I_DEPTH(256), .D_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .s_if(s_if), .reload(reload),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall),
    .i_r_enb(i_r_enb), .rd_enbl(rd_enbl), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [9:0]  addr;
    logic [31:0] dat;
  } wr_t;

  typedef struct {
    logic [31:0] hdr;
    logic        exp_err;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every enable pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (i_w_enb || d_w_enb) begin
      if (exp_q.size() == 0) begin
        check("spurious write", 32'({i_w_enb, d_w_enb}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write port", 32'({i_w_enb, d_w_enb}), mon_e.is_d ? 32'd1 : 32'd2);
        check("write addr", 32'(mon_e.is_d ? d_w_addr : i_w_addr), 32'(mon_e.addr));
        check("write data", mon_e.is_d ? d_w_dat : i_w_dat, mon_e.dat);
      end
    end
  end

  // Offer one word at a negedge and return at the negedge after acceptance.
  task automatic send_word(input logic [31:0] w, input bit push, input bit is_d, input logic [9:0] addr);
    int cyc = 0;
    s_if.s_dat   = w;
    s_if.s_valid = 1'b1;
    while (s_if.s_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (s_if.s_ready !== 1'b1) begin
      check("ready timeout", 32'(s_if.s_ready), 32'd1);
      s_if.s_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back({is_d, addr, w});
      @(negedge clk);
      s_if.s_valid = 1'b0;
    end
  endtask

  task automatic send_record(input logic [31:0] hdr, input logic exp_err);
    int          n;
    logic        is_d;
    logic [31:0] w;
    logic [31:0] sum;
    n    = int'(hdr[15:0]);
    is_d = hdr[30];
    sum  = 32'd0;
    send_word(hdr, 1'b0, 1'b0, 10'd0);
    if (!exp_err && !hdr[31]) begin
      for (int k = 0; k < n; k++) begin
        w   = $urandom;
        sum = sum + w;
        send_word(w, 1'b1, is_d, 10'(k * 4));
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      if (n != 0) send_word(sum, 1'b0, 1'b0, 10'd0);
`endif
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload err", 32'(err), 32'd0);
    check("reload s_ready", 32'(s_if.s_ready), 32'd1);
    check("reload pc_stall", 32'(pc_stall), 32'd1);
    check("reload init_done", 32'(d_bram_init_done), 32'd0);
    check("reload i_r_enb", 32'(i_r_enb), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0003, 1'b0};
    vecs[1] = '{32'h4000_0002, 1'b0};
    vecs[2] = '{32'h0000_0000, 1'b0};
    vecs[3] = '{32'h4000_0100, 1'b0};
    vecs[4] = '{32'h0000_0101, 1'b1};
    vecs[5] = '{32'h4000_0101, 1'b1};
    vecs[6] = '{32'h0001_0001, 1'b1};
    vecs[7] = '{32'hC000_0001, 1'b1};
    vecs[8] = '{32'h0000_0100, 1'b0};

    s_if.s_dat   = 32'd0;
    s_if.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst s_ready", 32'(s_if.s_ready), 32'd0);
    check("rst pc_stall", 32'(pc_stall), 32'd1);
    check("rst init_done", 32'(d_bram_init_done), 32'd0);
    check("rst i_r_enb", 32'(i_r_enb), 32'd0);
    check("rst rd_enbl", 32'(rd_enbl), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst enables", 32'({i_w_enb, d_w_enb}), 32'd0);
    check("rst i_w_addr", 32'(i_w_addr), 32'd0);
    check("rst d_w_dat", d_w_dat, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Header table: each record followed by a status check.
    for (int v = 0; v < 9; v++) begin
      send_record(vecs[v].hdr, vecs[v].exp_err);
      @(negedge clk);
      check($sformatf("vec%0d err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d s_ready", v), 32'(s_if.s_ready), 32'(!vecs[v].exp_err));
      check($sformatf("vec%0d pc_stall", v), 32'(pc_stall), 32'd1);
      check($sformatf("vec%0d drained", v), 32'(exp_q.size()), 32'd0);
      if (vecs[v].exp_err) do_reload();
    end

    // DATA record with 2-cycle valid gaps.
    send_word(32'h4000_0002, 1'b0, 1'b0, 10'd0);
    send_word(32'd5, 1'b1, 1'b1, 10'h000);
    repeat (2) @(negedge clk);
    send_word(32'd7, 1'b1, 1'b1, 10'h004);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(32'd12, 1'b0, 1'b0, 10'd0);
`endif
    @(negedge clk);
    check("gap drained", 32'(exp_q.size()), 32'd0);
    check("gap err", 32'(err), 32'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(32'h0000_0002, 1'b0, 1'b0, 10'd0);
    send_word(32'd1, 1'b1, 1'b0, 10'h000);
    send_word(32'd2, 1'b1, 1'b0, 10'h004);
    send_word(32'd3, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    check("cksum ok err", 32'(err), 32'd0);
    check("cksum ok s_ready", 32'(s_if.s_ready), 32'd1);
    send_word(32'h0000_0002, 1'b0, 1'b0, 10'd0);
    send_word(32'd1, 1'b1, 1'b0, 10'h000);
    send_word(32'd2, 1'b1, 1'b0, 10'h004);
    send_word(32'd4, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    check("cksum bad err", 32'(err), 32'd1);
    check("cksum bad s_ready", 32'(s_if.s_ready), 32'd0);
    do_reload();
`endif

    // START: core released one cycle after acceptance, stream ignored.
    send_word(32'h8000_0000, 1'b0, 1'b0, 10'd0);
    check("start pc_stall", 32'(pc_stall), 32'd0);
    check("start init_done", 32'(d_bram_init_done), 32'd1);
    check("start i_r_enb", 32'(i_r_enb), 32'd1);
    check("start rd_enbl", 32'(rd_enbl), 32'd1);
    check("start s_ready", 32'(s_if.s_ready), 32'd0);
    s_if.s_dat   = 32'h1234_5678;
    s_if.s_valid = 1'b1;
    repeat (5) @(negedge clk);
    s_if.s_valid = 1'b0;
    check("run s_ready", 32'(s_if.s_ready), 32'd0);
    check("run pc_stall", 32'(pc_stall), 32'd0);
    do_reload();

    // Reset in the middle of a 4-word record.
    send_word(32'h0000_0004, 1'b0, 1'b0, 10'd0);
    send_word(32'hDEAD_BEEF, 1'b1, 1'b0, 10'h000);
    #2 rst = 1'b0;
    #1;
    check("midrst s_ready", 32'(s_if.s_ready), 32'd0);
    check("midrst pc_stall", 32'(pc_stall), 32'd1);
    check("midrst enables", 32'({i_w_enb, d_w_enb}), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_word(32'h0000_0001, 1'b0, 1'b0, 10'd0);
    send_word(32'hCAFE_F00D, 1'b1, 1'b0, 10'h000);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(32'hCAFE_F00D, 1'b0, 1'b0, 10'd0);
`endif
    @(negedge clk);
    check("post-rst err", 32'(err), 32'd0);
    check("final drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
